fp_scan: RTL and testbench



---
 rtl/fp_scan_if.sv | 26 ++
 rtl/fp_scan.sv | 178 +++++++++++++++++
 tb/tb_fp_scan.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_scan_if.sv
// Front-panel scan bus: LED images and switch levels on the logic side, row/column/sense on the matrix side.
interface fp_scan_if;
  logic [0:11] addr_leds;
  logic [0:11] data_leds;
  logic [0:2]  ema_leds;
  logic        run_led;
  logic        power_led;
  logic [0:2]  row_n;
  logic [0:11] col;
  logic [0:11] sense;
  logic [0:8]  fnsw;
  logic [0:3]  rotsw;
  logic        frame_tick;

  // Scan controller side.
  modport master (
    input  addr_leds, data_leds, ema_leds, run_led, power_led, sense,
    output row_n, col, fnsw, rotsw, frame_tick
  );

  // Panel logic / matrix side.
  modport slave (
    output addr_leds, data_leds, ema_leds, run_led, power_led, sense,
    input  row_n, col, fnsw, rotsw, frame_tick
  );
endinterface

// File: rtl/fp_scan.sv
// Three-row multiplexed front-panel scanner with switch debouncing.
module fp_scan #(
  parameter int unsigned ROW_CYCLES     = 8333,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic      clock,
  input  logic      reset,
  fp_scan_if.master pnl
);

  localparam int unsigned CNT_W = $clog2(ROW_CYCLES);
  localparam int unsigned NSW   = 13;  // 9 function switches + 4 rotary bits
  localparam int unsigned DB_W  = 3;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       row_q, row_d;
  logic [0:2]       row_n_q, row_n_d;
  logic [0:11]      col_q, col_d;
  logic             frame_tick_q, frame_tick_d;
  logic             sample_en;
  logic [0:11]      image;
  logic [0:11]      sync1_q, sync2_q;
  logic [0:NSW-1]   samp, samp_mask;
  logic [0:NSW-1]   db_q, db_d;
  logic [DB_W-1:0]  dbc_q [NSW];
  logic [DB_W-1:0]  dbc_d [NSW];
  logic [0:3]       rotsw_q, rotsw_d;
  logic             unused_sense;

  // Row image selected by the current row.
  always_comb begin
    image = '0;
    case (row_q)
      2'd0:    image = pnl.addr_leds;
      2'd1:    image = pnl.data_leds;
      2'd2:    image = {pnl.ema_leds, pnl.run_led, pnl.power_led, 7'b0};
      default: image = '0;
    endcase
  end

  // State register: slot phase, slot counter and row index.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      row_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // Next state: blank lead-in, then drive until the slot ends and the row advances.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    row_d   = row_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (cnt_q == ROW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          row_d   = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Outputs: snapshot image and pull the row low on drive entry, go idle and sample at slot end.
  always_comb begin
    row_n_d      = row_n_q;
    col_d        = col_q;
    frame_tick_d = 1'b0;
    sample_en    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          col_d   = image;
          row_n_d = ~(3'b100 >> row_q);
        end
      end
      ST_DRIVE: begin
        if (cnt_q == ROW_LAST) begin
          col_d        = '0;
          row_n_d      = 3'b111;
          frame_tick_d = (row_q == 2'd2);
          sample_en    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered matrix drivers and frame pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_n_q      <= 3'b111;
      col_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      row_n_q      <= row_n_d;
      col_q        <= col_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Two-stage synchronizer for the asynchronous sense lines.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pnl.sense;
      sync2_q <= sync1_q;
    end
  end

  // Sense bits 9..11 carry no switches.
  assign unused_sense = ^sync2_q[9:11];

  // Debounce: count consecutive disagreeing samples, accept on the threshold.
  always_comb begin
    samp      = {sync2_q[0:8], sync2_q[0:3]};
    samp_mask = '0;
    if (sample_en) begin
      if (row_q == 2'd0) samp_mask = {9'h1FF, 4'h0};
      if (row_q == 2'd1) samp_mask = {9'h000, 4'hF};
    end
    db_d = db_q;
    for (int unsigned i = 0; i < NSW; i++) begin
      dbc_d[i] = dbc_q[i];
      if (samp_mask[i]) begin
        if (samp[i] == db_q[i]) begin
          dbc_d[i] = '0;
        end else if (dbc_q[i] == DB_LAST) begin
          db_d[i]  = samp[i];
          dbc_d[i] = '0;
        end else begin
          dbc_d[i] = dbc_q[i] + DB_W'(1);
        end
      end
    end
    // Rotary only follows a clean one-hot detent.
    rotsw_d = $onehot(db_d[9:12]) ? db_d[9:12] : rotsw_q;
  end

  // Debounce state and rotary hold register.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_q    <= '0;
      rotsw_q <= '0;
      for (int unsigned i = 0; i < NSW; i++) dbc_q[i] <= '0;
    end else begin
      db_q    <= db_d;
      rotsw_q <= rotsw_d;
      for (int unsigned i = 0; i < NSW; i++) dbc_q[i] <= dbc_d[i];
    end
  end

  assign pnl.row_n      = row_n_q;
  assign pnl.col        = col_q;
  assign pnl.fnsw       = db_q[0:8];
  assign pnl.rotsw      = rotsw_q;
  assign pnl.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_fp_scan.sv
// Self-checking bench for fp_scan with a cycle-level behavioural reference model.
module tb_fp_scan;

  localparam int ROWC = 20;
  localparam int BLK  = 4;
  localparam int DEB  = 3;

  logic clock;
  logic reset;

  fp_scan_if bus ();

  fp_scan #(.ROW_CYCLES(ROWC), .BLANK_CYCLES(BLK), .DEBOUNCE_SCANS(DEB)) dut (
    .clock (clock),
    .reset (reset),
    .pnl   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_t;          // cycles since the last reset edge
  logic [0:11] m_col;
  logic        m_tick;
  logic [0:11] h1, h2;       // sense seen one and two edges ago
  logic [0:12] m_db;
  int          m_run [13];
  logic [0:3]  m_rot;
  logic        row_mode;
  logic [0:11] rs [3];

  typedef struct {
    logic [0:11] a, d;
    logic [0:2]  e;
    logic        r, p;
    logic [0:11] c0, c1, c2;
  } img_vec_t;

  typedef struct {
    logic [0:11] s;
    logic [0:8]  fn;
    logic [0:3]  rot;
  } sns_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0o required=%0o", name, m_t, act, exp);
    end
  endtask

  function automatic logic [0:11] img_of(input int row);
    case (row)
      0:       return bus.addr_leds;
      1:       return bus.data_leds;
      default: return {bus.ema_leds, bus.run_led, bus.power_led, 7'b0};
    endcase
  endfunction

  task automatic model_reset();
    m_t = 0; m_col = '0; m_tick = 1'b0; h1 = '0; h2 = '0;
    m_db = '0; m_rot = '0;
    for (int i = 0; i < 13; i++) m_run[i] = 0;
  endtask

  task automatic db_step(input int i, input logic s);
    if (s == m_db[i]) m_run[i] = 0;
    else begin
      m_run[i]++;
      if (m_run[i] == DEB) begin
        m_db[i] = s;
        m_run[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    int ph, row;
    logic [0:2] er;
    ph = m_t % ROWC;
    row = (m_t / ROWC) % 3;
    er = 3'b111;
    if (ph >= BLK) er[row] = 1'b0;
    chk("row_n", 32'(bus.row_n), 32'(er));
    chk("col", 32'(bus.col), 32'(m_col));
    chk("frame_tick", 32'(bus.frame_tick), 32'(m_tick));
    chk("fnsw", 32'(bus.fnsw), 32'(m_db[0:8]));
    chk("rotsw", 32'(bus.rotsw), 32'(m_rot));
    chk("one_row_low", 32'($countones(~bus.row_n) <= 1), 32'd1);
    chk("col_idle", 32'(bus.col != 0 && bus.row_n == 3'b111), 32'd0);
  endtask

  // One clock: update the model from the pre-edge inputs, then compare after the edge.
  task automatic tick();
    logic        pre_rst;
    logic [0:11] cur_s, im;
    int          ph, row;
    if (row_mode) bus.sense = rs[(m_t / ROWC) % 3];
    pre_rst = reset;
    cur_s = bus.sense;
    ph = m_t % ROWC;
    row = (m_t / ROWC) % 3;
    im = img_of(row);
    @(posedge clock);
    if (pre_rst) model_reset();
    else begin
      m_tick = (ph == ROWC - 1) && (row == 2);
      if (ph == ROWC - 1 && row == 0) for (int i = 0; i < 9; i++) db_step(i, h2[i]);
      if (ph == ROWC - 1 && row == 1) begin
        for (int i = 0; i < 4; i++) db_step(9 + i, h2[i]);
        if ($countones(m_db[9:12]) == 1) m_rot = m_db[9:12];
      end
      h2 = h1;
      h1 = cur_s;
      if (ph == BLK - 1) m_col = im;
      else if (ph == ROWC - 1) m_col = '0;
      m_t++;
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_until(input int mod60);
    for (int k = 0; k < 60 && (m_t % 60) != mod60; k++) tick();
  endtask

  img_vec_t iv [4];
  sns_vec_t sv [4];

  initial begin
    iv[0] = '{12'o1234, 12'o5670, 3'o5, 1'b1, 1'b0, 12'o1234, 12'o5670, 12'o5400};
    iv[1] = '{12'o7777, 12'o0000, 3'o7, 1'b1, 1'b1, 12'o7777, 12'o0000, 12'o7600};
    iv[2] = '{12'o0001, 12'o4000, 3'o2, 1'b0, 1'b1, 12'o0001, 12'o4000, 12'o2200};
    iv[3] = '{12'o5252, 12'o2525, 3'o0, 1'b0, 1'b0, 12'o5252, 12'o2525, 12'o0000};
    sv[0] = '{12'b0100_0000_0000, 9'b010000000, 4'b0100};
    sv[1] = '{12'b0000_1000_0011, 9'b000010000, 4'b0100};
    sv[2] = '{12'b0110_0000_0000, 9'b011000000, 4'b0100};
    sv[3] = '{12'b0001_0000_0100, 9'b000100000, 4'b0001};

    bus.addr_leds = '0; bus.data_leds = '0; bus.ema_leds = '0;
    bus.run_led = 1'b0; bus.power_led = 1'b0; bus.sense = '0;
    row_mode = 1'b0;
    rs[0] = '0; rs[1] = '0; rs[2] = '0;
    model_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_row_n", 32'(bus.row_n), 32'(3'b111));
    chk("rst_col", 32'(bus.col), 32'd0);
    chk("rst_fnsw", 32'(bus.fnsw), 32'd0);

    // Scan timing and row images.
    do_reset();
    for (int v = 0; v < 4; v++) begin
      bus.addr_leds = iv[v].a; bus.data_leds = iv[v].d; bus.ema_leds = iv[v].e;
      bus.run_led = iv[v].r; bus.power_led = iv[v].p;
      for (int k = 0; k < 60; k++) begin
        tick();
        if (m_t % 60 == 3)  chk("t1_blank", 32'(bus.row_n), 32'(3'b111));
        if (m_t % 60 == 4)  chk("t1_row0", 32'(bus.row_n), 32'(3'b011));
        if (m_t % 60 == 10) chk("t1_col0", 32'(bus.col), 32'(iv[v].c0));
        if (m_t % 60 == 30) chk("t1_col1", 32'(bus.col), 32'(iv[v].c1));
        if (m_t % 60 == 50) chk("t1_col2", 32'(bus.col), 32'(iv[v].c2));
      end
    end

    // Image snapshot held for the whole slot.
    bus.addr_leds = 12'o1234;
    run_until(10);
    bus.addr_leds = 12'o7777;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("t2_hold", 32'(bus.col), 32'o1234);
    end
    run_until(4);
    chk("t2_next", 32'(bus.col), 32'o7777);

    // Switch table incl. rotary validity.
    for (int v = 0; v < 4; v++) begin
      bus.sense = sv[v].s;
      repeat (300) tick();
      chk("t5_fnsw", 32'(bus.fnsw), 32'(sv[v].fn));
      chk("t5_rotsw", 32'(bus.rotsw), 32'(sv[v].rot));
    end

    // Debounce accept latency.
    bus.sense = '0;
    do_reset();
    bus.sense = 12'b0010_0000_0000;
    repeat (139) tick();
    chk("t3_before", 32'(bus.fnsw), 32'd0);
    tick();
    chk("t3_accept", 32'(bus.fnsw), 32'(9'b001000000));

    // Glitch reject, then a normal accept.
    bus.sense = '0;
    do_reset();
    bus.sense = 12'b0000_0100_0000;
    repeat (100) tick();
    bus.sense = '0;
    repeat (100) tick();
    chk("t4_glitch", 32'(bus.fnsw), 32'd0);
    bus.sense = 12'b0000_0100_0000;
    repeat (179) tick();
    chk("t4_before", 32'(bus.fnsw), 32'd0);
    tick();
    chk("t4_accept", 32'(bus.fnsw), 32'(9'b000001000));

    // Mid-operation reset during row1 drive.
    bus.sense = '0;
    do_reset();
    row_mode = 1'b1;
    rs[0] = 12'o4000; rs[1] = 12'o1000; rs[2] = 12'o7777;
    repeat (240) tick();
    chk("t6_fnsw_set", 32'(bus.fnsw), 32'o400);
    chk("t6_rot_set", 32'(bus.rotsw), 32'(4'b0010));
    run_until(30);
    do_reset();
    chk("t6_row_n", 32'(bus.row_n), 32'(3'b111));
    chk("t6_col", 32'(bus.col), 32'd0);
    chk("t6_fnsw", 32'(bus.fnsw), 32'd0);
    chk("t6_rotsw", 32'(bus.rotsw), 32'd0);
    repeat (139) tick();
    chk("t6_before", 32'(bus.fnsw), 32'd0);
    tick();
    chk("t6_reaccept", 32'(bus.fnsw), 32'o400);

    // Randomized images, per-row sense and occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) begin
        case ($urandom_range(4))
          0: bus.addr_leds = 12'($urandom);
          1: bus.data_leds = 12'($urandom);
          2: bus.ema_leds = 3'($urandom);
          3: bus.run_led = 1'($urandom);
          default: bus.power_led = 1'($urandom);
        endcase
      end
      if ($urandom_range(99) == 0) begin
        int r;
        r = $urandom_range(2);
        if ($urandom_range(1) == 0) rs[r] = 12'($urandom);
        else rs[r][$urandom_range(11)] = ~rs[r][$urandom_range(11)];
      end
      reset = ($urandom_range(1499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
